// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 5-stage MIPS pipeline.
// It captures one execute result and performs the LW/SW access over a req/ack data bus.
// If the bus does not ack within TIMEOUT cycles, the stage returns a bus error.
// Optional macro MEM_ALIGN_CHECK_EN: when defined, a misaligned LW/SW returns a bus error
// without issuing a request.
module mem_access_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done_in,
    output logic              ready_out,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic [1:0]        mem_op,
    input  logic [4:0]        reg_dest,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] lData,
    output logic [DATA_W-1:0] result_fromALU,
    output logic [1:0]        mem_op_out,
    output logic [4:0]        reg_dest_out,
    output logic              done_out,
    output logic              bus_err
);

    localparam logic [1:0] OP_LW = 2'b01;
    localparam logic [1:0] OP_SW = 2'b10;

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t            state_q;
    logic [7:0]        timer_q;
    logic              req_q, we_q, done_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, ldata_q, alu_q;
    logic [1:0]        op_q;
    logic [4:0]        rd_q;

    logic is_mem_d;
    logic misalign_d;

    // Decode the incoming op; reserved encoding 11 behaves like NONE.
    always_comb begin
        is_mem_d = (mem_op == OP_LW) || (mem_op == OP_SW);
`ifdef MEM_ALIGN_CHECK_EN
        misalign_d = (alu_result[1:0] != 2'b00);
`else
        misalign_d = 1'b0;
`endif
    end

    // Stage FSM: capture in IDLE, hold the bus request in ACCESS until ack or timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ldata_q <= '0;
            alu_q   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (done_in) begin
                        alu_q <= alu_result;
                        op_q  <= mem_op;
                        rd_q  <= reg_dest;
                        if (is_mem_d && misalign_d) begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            ldata_q <= '0;
                        end else if (is_mem_d) begin
                            state_q <= S_ACCESS;
                            req_q   <= 1'b1;
                            we_q    <= (mem_op == OP_SW);
                            addr_q  <= ADDR_W'(alu_result);
                            wdata_q <= store_data;
                            timer_q <= '0;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    // Ack takes priority over a timeout that expires in the same cycle.
                    if (dmem_ack) begin
                        if (!we_q) ldata_q <= dmem_rdata;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (timer_q == 8'(TIMEOUT - 1)) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        ldata_q <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready_out      = (state_q == S_IDLE);
    assign dmem_req       = req_q;
    assign dmem_we        = we_q;
    assign dmem_addr      = addr_q;
    assign dmem_wdata     = wdata_q;
    assign lData          = ldata_q;
    assign result_fromALU = alu_q;
    assign mem_op_out     = op_q;
    assign reg_dest_out   = rd_q;
    assign done_out       = done_q;
    assign bus_err        = err_q;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage 32-bit MIPS pipeline, between execute and writeBack.
- Captures one execute-stage result and performs the LW/SW data-memory access over a variable-latency req/ack bus.
- Presents load data, ALU result, destination register and a one-cycle done pulse to writeBack.
- Stalls execute via ready_out while an access is outstanding.

Parameters:
DATA_W, 32, data/ALU word width
ADDR_W, 32, data-memory byte-address width
TIMEOUT, 15, max cycles waiting for dmem_ack before bus error (1..255)

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  synchronous, active-high reset
done_in  input  1  execute result valid this cycle
ready_out  output  1  stage can accept done_in this cycle
alu_result  input  DATA_W  ALU result; also the memory address for LW/SW
store_data  input  DATA_W  rt value for SW
mem_op  input  2  00 NONE, 01 LW, 10 SW, 11 reserved (treated as NONE)
reg_dest  input  5  destination register
dmem_req  output  1  memory request, held until ack or timeout
dmem_we  output  1  1 = write (SW)
dmem_addr  output  ADDR_W  byte address
dmem_wdata  output  DATA_W  store data
dmem_ack  input  1  request complete; dmem_rdata valid same cycle for reads
dmem_rdata  input  DATA_W  read data
lData  output  DATA_W  load data to writeBack
result_fromALU  output  DATA_W  captured ALU result to writeBack
mem_op_out  output  2  captured mem_op
reg_dest_out  output  5  captured reg_dest
done_out  output  1  one-cycle pulse: outputs valid for writeBack
bus_err  output  1  one-cycle pulse coincident with done_out on timeout/fault

Behaviour:
- Reset (rst=1 at posedge):
  - state IDLE, ready_out=1, dmem_req=0, dmem_we=0.
  - dmem_addr, dmem_wdata, lData, result_fromALU = 0; mem_op_out=00, reg_dest_out=0.
  - done_out=0, bus_err=0, timer=0.
- Reset mid-access: dmem_req drops on the next cycle and the transaction is discarded; no done_out is produced.
- FSM states: IDLE, ACCESS.
- IDLE (ready_out=1); on done_in=1:
  - Capture alu_result, store_data, mem_op, reg_dest.
  - NONE/reserved: next cycle done_out=1, lData unchanged; stay IDLE. Latency 1.
  - LW/SW: next cycle enter ACCESS with dmem_req=1, dmem_addr=alu_result, dmem_we=(mem_op==SW), dmem_wdata=store_data; timer=0.
- ACCESS (ready_out=0; done_in ignored):
  - dmem_req, addr, we and wdata are held stable.
  - timer increments each cycle without ack.
  - dmem_ack=1: LW latches lData=dmem_rdata; SW leaves lData unchanged. Next cycle: dmem_req=0, done_out=1, return to IDLE. Minimum LW/SW latency is 2 cycles (ack in the first ACCESS cycle).
  - Timeout: when timer==TIMEOUT-1 with no ack, next cycle dmem_req=0, done_out=1, bus_err=1, lData=0; return to IDLE.
  - If ack and timeout coincide, ack wins.
- dmem_ack while IDLE is ignored.
- done_out and bus_err are registered single-cycle pulses.
- Captured outputs (result_fromALU, mem_op_out, reg_dest_out, lData) hold until the next capture.
- No downstream backpressure; writeBack always consumes done_out.
- Back-to-back NONE ops accept one per cycle.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: for LW/SW with alu_result[1:0]!=0, no request is issued. Next cycle done_out=1, bus_err=1, lData=0; stay IDLE.
- Not defined: no alignment check; dmem_addr is driven with the low bits unchanged.

Test Plan:
- Reset, then done_in=1, mem_op=00, alu_result=32'h0000_0005, reg_dest=3 -> next cycle done_out=1, result_fromALU=5, reg_dest_out=3, dmem_req never asserted.
- LW addr 32'h100, ack after 3 cycles with rdata=32'hDEAD_BEEF -> dmem_req high 3 cycles, ready_out=0 throughout, then done_out=1 with lData=32'hDEAD_BEEF, ready_out=1.
- SW addr 32'h104, store_data=32'h1234 -> dmem_we=1, dmem_wdata=32'h1234 stable until ack; done_out=1 with lData unchanged.
- LW with no ack, TIMEOUT=15 -> dmem_req high exactly 15 cycles, then done_out=1, bus_err=1, lData=0.
- rst=1 during ACCESS cycle 2 -> dmem_req=0 next cycle, no done_out; a new NONE op afterwards completes in 1 cycle.
- With MEM_ALIGN_CHECK_EN: LW addr 32'h102 -> no dmem_req, next cycle done_out=1, bus_err=1.
